// File: rtl/hax_floor_request_scheduler.sv
// Floor-select request scheduler: captures key presses into a pending set and
// offers targets to the elevator core in SCAN order over a valid/ready handshake.
module hax_floor_request_scheduler #(
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_W    = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  KEY0_n,
  input  logic                  req_key_n,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  tgt_ready,
  output logic                  tgt_valid,
  output logic [FLOOR_W-1:0]    tgt_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_OFFER
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [NUM_FLOORS-1:0]   set_mask, clr_mask;
  logic [FLOOR_W-1:0]      tgt_q, tgt_d;
  logic                    dir_q, dir_d;
  logic                    key_prev_q;
  logic                    press;
  logic                    above_hit, below_hit;
  logic [FLOOR_W-1:0]      above_idx, below_idx;

  assign press = key_prev_q & ~req_key_n;

  // Shifting past the vector width yields zero, so out-of-range floors drop out.
  assign set_mask = press ? (NUM_FLOORS'(1) << req_floor) : '0;

  // Lowest pending floor above cur_floor and highest pending floor below it.
  always_comb begin
    above_hit = 1'b0;
    above_idx = '0;
    below_hit = 1'b0;
    below_idx = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && ((FLOOR_W+1)'(i) > {1'b0, cur_floor}) && !above_hit) begin
        above_hit = 1'b1;
        above_idx = FLOOR_W'(i);
      end
      if (pending_q[i] && ((FLOOR_W+1)'(i) < {1'b0, cur_floor})) begin
        below_hit = 1'b1;
        below_idx = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    dir_d    = dir_q;
    clr_mask = '0;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (dir_q) begin
          if (above_hit) begin
            tgt_d   = above_idx;
            state_d = S_OFFER;
          end else if (below_hit) begin
            tgt_d   = below_idx;
            dir_d   = 1'b0;
            state_d = S_OFFER;
          end else begin
            clr_mask = NUM_FLOORS'(1) << cur_floor;
            state_d  = S_IDLE;
          end
        end else begin
          if (below_hit) begin
            tgt_d   = below_idx;
            state_d = S_OFFER;
          end else if (above_hit) begin
            tgt_d   = above_idx;
            dir_d   = 1'b1;
            state_d = S_OFFER;
          end else begin
            clr_mask = NUM_FLOORS'(1) << cur_floor;
            state_d  = S_IDLE;
          end
        end
      end
      S_OFFER: begin
        if (tgt_ready) begin
          clr_mask = NUM_FLOORS'(1) << tgt_q;
          // A press landing on the transfer edge counts as remaining work.
          state_d  = (|((pending_q | set_mask) & ~clr_mask)) ? S_SELECT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Clear is applied after set so a same-edge press of the cleared floor loses.
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0_n) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      tgt_q      <= '0;
      dir_q      <= 1'b1;
      key_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      tgt_q      <= tgt_d;
      dir_q      <= dir_d;
      key_prev_q <= req_key_n;
    end
  end

  assign tgt_valid = (state_q == S_OFFER);
  assign tgt_floor = tgt_q;
  assign pending   = pending_q;
  assign dir_up    = dir_q;

endmodule
